alu_regfile_core: RTL

Parametrised successor to the team's 16×8-bit memory-to-memory ALU. It executes one three-address instruction at a time against an internal register file of `2**ADDR_W` words of `DATA_W` bits. It adds a valid/ready instruction handshake, a result strobe, corrected signed-compare and shift opcodes, and a multi-cycle iterative divider. It sits between the instruction sequencer and any consumer of write-back results.

---
 rtl/alu_regfile_core_pkg.sv | 31 +++
 rtl/alu_regfile_core_if.sv | 30 +++
 rtl/alu_regfile_core_seq_divider.sv | 54 +++++
 rtl/alu_regfile_core.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/alu_regfile_core_pkg.sv
// alu_core_pkg: shared types for alu_regfile_core.
//   alu_op_e    - 4-bit opcode map
//   alu_state_e - control FSM states
//   FLD_*       - instruction field positions, in units of ADDR_W above the
//                 4-bit opcode-free base (dst is the lowest field)
package alu_core_pkg;

  typedef enum logic [3:0] {
    OP_LDI = 4'd0,  OP_EQ  = 4'd1,  OP_LTU = 4'd2,  OP_LEU = 4'd3,
    OP_OR  = 4'd4,  OP_LTS = 4'd5,  OP_LES = 4'd6,  OP_SHL = 4'd7,
    OP_AND = 4'd8,  OP_XOR = 4'd9,  OP_NOT = 4'd10, OP_ADD = 4'd11,
    OP_SUB = 4'd12, OP_MUL = 4'd13, OP_DIV = 4'd14, OP_MOD = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DIV  = 2'd2
  } alu_state_e;

  localparam int OP_W     = 4;
  localparam int FLD_DST  = 0;
  localparam int FLD_SRC2 = 1;
  localparam int FLD_SRC1 = 2;
  localparam int FLD_OP   = 3;

  function automatic logic is_div_op(input alu_op_e op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_regfile_core_if.sv
// alu_regfile_core_if: instruction/result/debug bus of alu_regfile_core.
//   master - sequencer side (drives instr_valid/instr/dbg_addr)
//   slave  - core side (drives instr_ready, result_*, illegal, div_zero, dbg_data)
interface alu_regfile_core_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic                  instr_valid;
  logic                  instr_ready;
  logic [4+3*ADDR_W-1:0] instr;
  logic                  result_valid;
  logic [ADDR_W-1:0]     result_addr;
  logic [DATA_W-1:0]     result_data;
  logic                  illegal;
  logic                  div_zero;
  logic [ADDR_W-1:0]     dbg_addr;
  logic [DATA_W-1:0]     dbg_data;

  modport master (
    output instr_valid, instr, dbg_addr,
    input  instr_ready, result_valid, result_addr, result_data,
           illegal, div_zero, dbg_data
  );

  modport slave (
    input  instr_valid, instr, dbg_addr,
    output instr_ready, result_valid, result_addr, result_data,
           illegal, div_zero, dbg_data
  );
endinterface

// File: rtl/alu_regfile_core_seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per clock.
//   start            - load dividend/divisor, begin DATA_W steps
//   done             - high during the cycle whose edge performs the last step
//   quotient/remainder - combinational result of the step taken at the next
//                      edge; final values when done is high
//   dz               - divisor of the current operation was zero
// Divide by zero falls out of the algorithm: every trial subtract succeeds,
// so the quotient is all ones and the remainder ends up equal to the dividend.
module seq_divider #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              dz
);
  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W:0]   shl, trial;

  // Dividend bits shift out of quo_q into the partial remainder MSB-first.
  assign shl       = {rem_q, quo_q[DATA_W-1]};
  assign trial     = shl - {1'b0, dvs_q};
  assign remainder = trial[DATA_W] ? shl[DATA_W-1:0] : trial[DATA_W-1:0];
  assign quotient  = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
  assign done      = (cnt_q == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      dz    <= 1'b0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= CW'(DATA_W);
      dz    <= (divisor == '0);
    end else if (cnt_q != '0) begin
      rem_q <= remainder;
      quo_q <= quotient;
      cnt_q <= cnt_q - CW'(1);
    end
  end
endmodule

// File: rtl/alu_regfile_core.sv
// alu_regfile_core: three-address ALU over a 2**ADDR_W x DATA_W register file.
//   clk, rst - rising-edge clock, async active-high reset
//   bus      - alu_regfile_core_if.slave: instr valid/ready, result strobe,
//              illegal / div_zero pulses, combinational debug read port
// Build option: define ALU_DIV_EN to build the iterative divider for ops
// 14/15 (DIV/MOD). Without it those ops pulse illegal and write nothing.
module alu_regfile_core
  import alu_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input logic               clk,
  input logic               rst,
  alu_regfile_core_if.slave bus
);
  localparam int SHW   = $clog2(DATA_W);
  localparam int IMM_W = 2 * ADDR_W;
  localparam int IW    = OP_W + 3 * ADDR_W;

  alu_state_e        state, state_nxt;
  logic [IW-1:0]     ir;
  alu_op_e           op;
  logic [ADDR_W-1:0] a1, a2, ad;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] r1, r2, imm, alu_res, wr_data;
  logic              wr_en, ill, dz_wr;

  assign op = alu_op_e'(ir[FLD_OP*ADDR_W +: OP_W]);
  assign a1 = ir[FLD_SRC1*ADDR_W +: ADDR_W];
  assign a2 = ir[FLD_SRC2*ADDR_W +: ADDR_W];
  assign ad = ir[FLD_DST*ADDR_W +: ADDR_W];
  assign r1 = mem[a1];
  assign r2 = mem[a2];

  assign bus.instr_ready = (state == IDLE);
  assign bus.dbg_data    = mem[bus.dbg_addr];

  // LDI immediate {src1,src2}, zero-extended or truncated to DATA_W.
  if (DATA_W > IMM_W) begin : g_imm_ext
    assign imm = {{(DATA_W-IMM_W){1'b0}}, a1, a2};
  end else if (DATA_W == IMM_W) begin : g_imm_eq
    assign imm = {a1, a2};
  end else begin : g_imm_trunc
    logic [IMM_W-1:0] imm_full;
    assign imm_full = {a1, a2};
    assign imm      = imm_full[DATA_W-1:0];
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_LDI: alu_res = imm;
      OP_EQ:  alu_res = {{(DATA_W-1){1'b0}}, r1 == r2};
      OP_LTU: alu_res = {{(DATA_W-1){1'b0}}, r1 <  r2};
      OP_LEU: alu_res = {{(DATA_W-1){1'b0}}, r1 <= r2};
      OP_OR:  alu_res = r1 | r2;
      OP_LTS: alu_res = {{(DATA_W-1){1'b0}}, $signed(r1) <  $signed(r2)};
      OP_LES: alu_res = {{(DATA_W-1){1'b0}}, $signed(r1) <= $signed(r2)};
      OP_SHL: alu_res = r1 << r2[SHW-1:0];
      OP_AND: alu_res = r1 & r2;
      OP_XOR: alu_res = r1 ^ r2;
      OP_NOT: alu_res = ~r1;
      OP_ADD: alu_res = r1 + r2;
      OP_SUB: alu_res = r1 - r2;
      OP_MUL: alu_res = r1 * r2;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_DIV_EN
  logic              div_start, div_done, div_dz;
  logic [DATA_W-1:0] div_q, div_r;

  seq_divider #(.DATA_W(DATA_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (r1),
    .divisor  (r2),
    .done     (div_done),
    .quotient (div_q),
    .remainder(div_r),
    .dz       (div_dz)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_data   = alu_res;
    ill       = 1'b0;
    dz_wr     = 1'b0;
`ifdef ALU_DIV_EN
    div_start = 1'b0;
`endif
    case (state)
      IDLE: if (bus.instr_valid) state_nxt = EXEC;
      EXEC: begin
        state_nxt = IDLE;
        if (is_div_op(op)) begin
`ifdef ALU_DIV_EN
          div_start = 1'b1;
          state_nxt = DIV;
`else
          ill = 1'b1;
`endif
        end else begin
          wr_en = 1'b1;
        end
      end
      DIV: begin
`ifdef ALU_DIV_EN
        // Written on the edge of the last divider step, using its
        // combinational result rather than waiting an extra cycle.
        if (div_done) begin
          wr_en     = 1'b1;
          wr_data   = (op == OP_DIV) ? div_q : div_r;
          dz_wr     = div_dz;
          state_nxt = IDLE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ir <= '0;
    else if (bus.instr_valid && bus.instr_ready) ir <= bus.instr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[ad] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.result_valid <= 1'b0;
      bus.result_addr  <= '0;
      bus.result_data  <= '0;
      bus.illegal      <= 1'b0;
      bus.div_zero     <= 1'b0;
    end else begin
      bus.result_valid <= wr_en;
      bus.illegal      <= ill;
      bus.div_zero     <= dz_wr;
      if (wr_en) begin
        bus.result_addr <= ad;
        bus.result_data <= wr_data;
      end
    end
  end
endmodule
